// File: rtl/dynamic_brunch_predictor_pkg.sv
// Shared fetch types and branch encodings for the dynamic predictor.
// Consumed by dynamic_brunch_predictor and brunch_btb.
package dynamic_brunch_predictor_pkg;

  typedef logic [31:0] PC;

  typedef struct packed {
    PC           pc;
    logic [31:0] inst;
    logic        is_brunch;
    logic        brunch_taken;
  } INST;

  typedef enum logic [1:0] {
    BR_NONE     = 2'd0,
    BR_COND     = 2'd1,
    BR_DIRECT   = 2'd2,
    BR_INDIRECT = 2'd3
  } BR_KIND;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;

  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_JALR = 6'b001001;

  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  // Weakly not-taken: MSB clear, all lower bits set.
  function automatic int bht_weak_nt(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

endpackage

// File: rtl/dynamic_brunch_predictor_btb.sv
// Direct-mapped BTB: async-reset valid bits, comb read, sync write.
// Only instantiated when BRUNCH_BTB_EN is defined.
import dynamic_brunch_predictor_pkg::*;

module brunch_btb #(
  parameter int ENTRIES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  PC    rd_pc,
  output logic hit,
  output PC    rd_target,
  input  logic wr_en,
  input  PC    wr_pc,
  input  PC    wr_target
);

  localparam int IW = $clog2(ENTRIES);
  localparam int TW = 30 - IW;

  logic [ENTRIES-1:0] valid;
  logic [TW-1:0]      tag [ENTRIES];
  PC                  target [ENTRIES];

  logic [IW-1:0] rd_idx;
  logic [IW-1:0] wr_idx;
  logic          unused_lo;

  assign rd_idx    = rd_pc[IW+1:2];
  assign wr_idx    = wr_pc[IW+1:2];
  assign unused_lo = ^{rd_pc[1:0], wr_pc[1:0]};

  assign hit       = valid[rd_idx] && (tag[rd_idx] == rd_pc[31:IW+2]);
  assign rd_target = target[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Payload needs no reset: a cleared valid bit hides it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag[wr_idx]    <= wr_pc[31:IW+2];
      target[wr_idx] <= wr_target;
    end
  end

endmodule

// File: rtl/dynamic_brunch_predictor.sv
// Fetch-stage predictor: decode, 2-bit BHT, optional BTB.
// Define BRUNCH_BTB_EN to build the BTB for indirect jumps.
import dynamic_brunch_predictor_pkg::*;

module dynamic_brunch_predictor #(
  parameter int BHT_ENTRIES    = 64,
  parameter int BTB_ENTRIES    = 16,
  parameter int CNT_WIDTH      = 2,
  parameter int MISS_CNT_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  INST                       inst_in,
  output INST                       inst_out,
  output PC                         brunch_address,
  input  logic                      upd_valid,
  input  PC                         upd_pc,
  input  BR_KIND                    upd_kind,
  input  logic                      upd_taken,
  input  PC                         upd_target,
  input  logic                      upd_mispredict,
  output logic [MISS_CNT_WIDTH-1:0] miss_count
);

  localparam int BHT_IW = $clog2(BHT_ENTRIES);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_INIT =
    CNT_WIDTH'(bht_weak_nt(CNT_WIDTH));
  localparam logic [MISS_CNT_WIDTH-1:0] MISS_MAX = '1;

  logic [CNT_WIDTH-1:0] bht [BHT_ENTRIES];

  logic [5:0]  op;
  logic [4:0]  rt;
  logic [5:0]  funct;
  logic [15:0] imm;
  BR_KIND      kind;

  PC pc_4;
  PC dir_target;
  PC cond_target;
  PC btb_target;

  logic [BHT_IW-1:0] bht_idx;
  logic [BHT_IW-1:0] upd_idx;
  logic              cond_taken;
  logic              btb_hit;
  logic              unused_ok;

  assign op    = inst_in.inst[31:26];
  assign rt    = inst_in.inst[20:16];
  assign funct = inst_in.inst[5:0];
  assign imm   = inst_in.inst[15:0];

  assign pc_4        = inst_in.pc + 32'd4;
  assign dir_target  = {pc_4[31:28], inst_in.inst[25:0], 2'b00};
  assign cond_target = pc_4 + {{14{imm[15]}}, imm, 2'b00};

  assign bht_idx    = inst_in.pc[BHT_IW+1:2];
  assign upd_idx    = upd_pc[BHT_IW+1:2];
  assign cond_taken = bht[bht_idx][CNT_WIDTH-1];

  assign unused_ok = ^{inst_in.is_brunch, inst_in.brunch_taken,
                       upd_pc, upd_target, (BTB_ENTRIES > 0)};

`ifdef BRUNCH_BTB_EN
  brunch_btb #(
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_pc     (inst_in.pc),
    .hit       (btb_hit),
    .rd_target (btb_target),
    .wr_en     (upd_valid && (upd_kind == BR_INDIRECT)),
    .wr_pc     (upd_pc),
    .wr_target (upd_target)
  );
`else
  assign btb_hit    = 1'b0;
  assign btb_target = '0;
`endif

  always_comb begin
    kind = BR_NONE;
    unique case (1'b1)
      (op inside {OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ}):
        kind = BR_COND;
      (op == OP_REGIMM):
        if (rt inside {RT_BLTZ, RT_BGEZ, RT_BLTZAL, RT_BGEZAL})
          kind = BR_COND;
      (op inside {OP_J, OP_JAL}):
        kind = BR_DIRECT;
      (op == OP_SPECIAL):
        if (funct inside {FN_JR, FN_JALR})
          kind = BR_INDIRECT;
      default: ;
    endcase
  end

  always_comb begin
    inst_out              = inst_in;
    inst_out.is_brunch    = 1'b0;
    inst_out.brunch_taken = 1'b0;
    brunch_address        = pc_4;
    unique case (1'b1)
      (kind == BR_DIRECT): begin
        inst_out.is_brunch    = 1'b1;
        inst_out.brunch_taken = 1'b1;
        brunch_address        = dir_target;
      end
      (kind == BR_COND): begin
        inst_out.is_brunch    = 1'b1;
        inst_out.brunch_taken = cond_taken;
        if (cond_taken) brunch_address = cond_target;
      end
      (kind == BR_INDIRECT): begin
        inst_out.is_brunch    = 1'b1;
        inst_out.brunch_taken = btb_hit;
        if (btb_hit) brunch_address = btb_target;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= CNT_INIT;
    end else if (upd_valid && (upd_kind == BR_COND)) begin
      if (upd_taken && (bht[upd_idx] != CNT_MAX))
        bht[upd_idx] <= bht[upd_idx] + CNT_WIDTH'(1);
      else if (!upd_taken && (bht[upd_idx] != '0))
        bht[upd_idx] <= bht[upd_idx] - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_count <= '0;
    end else if (upd_valid && upd_mispredict && (miss_count != MISS_MAX)) begin
      miss_count <= miss_count + MISS_CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_dynamic_brunch_predictor.sv
// Self-checking bench for dynamic_brunch_predictor.
// Reference model tracks the tables as plain integer arrays.
module tb_dynamic_brunch_predictor;
  import dynamic_brunch_predictor_pkg::*;

  localparam int BHT_N = 64;
  localparam int BTB_N = 16;
  localparam int CW    = 2;
  localparam int MW    = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  INST           inst_in;
  INST           inst_out;
  PC             brunch_address;
  logic          upd_valid;
  PC             upd_pc;
  BR_KIND        upd_kind;
  logic          upd_taken;
  PC             upd_target;
  logic          upd_mispredict;
  logic [MW-1:0] miss_count;

  int errors = 0;
  int checks = 0;

  int          m_bht [BHT_N];
  bit          m_bv  [BTB_N];
  int unsigned m_tag [BTB_N];
  int unsigned m_tgt [BTB_N];
  int          m_miss;

  always #5 clk = ~clk;

  dynamic_brunch_predictor #(
    .BHT_ENTRIES    (BHT_N),
    .BTB_ENTRIES    (BTB_N),
    .CNT_WIDTH      (CW),
    .MISS_CNT_WIDTH (MW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .inst_in        (inst_in),
    .inst_out       (inst_out),
    .brunch_address (brunch_address),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_kind       (upd_kind),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_mispredict (upd_mispredict),
    .miss_count     (miss_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < BHT_N; i++) m_bht[i] = (1 << (CW - 1)) - 1;
    for (int i = 0; i < BTB_N; i++) m_bv[i] = 1'b0;
    m_miss = 0;
  endfunction

  function automatic void predict(input int unsigned pc,
                                  input int unsigned ins,
                                  output bit ib, output bit tk,
                                  output int unsigned addr);
    int unsigned op, rt, fn, nxt, bi;
    int imm;
    op  = ins >> 26;
    rt  = (ins >> 16) & 31;
    fn  = ins & 63;
    nxt = pc + 4;
    imm = (ins & 32'h8000) != 0 ? int'(ins & 32'hFFFF) - 65536
                                : int'(ins & 32'hFFFF);
    ib = 0; tk = 0; addr = nxt;
    if (op == 2 || op == 3) begin
      ib = 1; tk = 1;
      addr = (nxt & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 4);
    end else if ((op >= 4 && op <= 7) ||
                 (op == 1 && (rt == 0 || rt == 1 || rt == 16 || rt == 17))) begin
      ib = 1;
      tk = m_bht[(pc / 4) % BHT_N] >= (1 << (CW - 1));
      if (tk) addr = nxt + int'(imm * 4);
    end else if (op == 0 && (fn == 8 || fn == 9)) begin
      ib = 1;
      bi = (pc / 4) % BTB_N;
`ifdef BRUNCH_BTB_EN
      if (m_bv[bi] && m_tag[bi] == pc / (4 * BTB_N)) begin
        tk = 1; addr = m_tgt[bi];
      end
`endif
    end
  endfunction

  task automatic check_pred(input string tag);
    bit ib, tk;
    int unsigned addr;
    predict(inst_in.pc, inst_in.inst, ib, tk, addr);
    chk({tag, ".is_brunch"}, 32'(inst_out.is_brunch), 32'(ib));
    chk({tag, ".taken"}, 32'(inst_out.brunch_taken), 32'(tk));
    chk({tag, ".addr"}, brunch_address, addr);
    chk({tag, ".pc"}, inst_out.pc, inst_in.pc);
    chk({tag, ".inst"}, inst_out.inst, inst_in.inst);
    chk({tag, ".miss"}, 32'(miss_count), 32'(m_miss));
  endtask

  task automatic tick();
    int unsigned i;
    @(posedge clk);
    if (rst_n && upd_valid) begin
      i = (upd_pc / 4) % BHT_N;
      if (upd_kind == BR_COND) begin
        if (upd_taken && m_bht[i] < (1 << CW) - 1) m_bht[i]++;
        else if (!upd_taken && m_bht[i] > 0) m_bht[i]--;
      end
`ifdef BRUNCH_BTB_EN
      if (upd_kind == BR_INDIRECT) begin
        i = (upd_pc / 4) % BTB_N;
        m_bv[i] = 1'b1;
        m_tag[i] = upd_pc / (4 * BTB_N);
        m_tgt[i] = upd_target;
      end
`endif
      if (upd_mispredict && m_miss < (1 << MW) - 1) m_miss++;
    end
    #1;
  endtask

  task automatic fetch(input PC pc, input logic [31:0] ins);
    inst_in = '0;
    inst_in.pc = pc;
    inst_in.inst = ins;
  endtask

  task automatic upd(input logic v, input PC pc, input BR_KIND k,
                     input logic t, input PC tgt, input logic mp);
    upd_valid = v; upd_pc = pc; upd_kind = k;
    upd_taken = t; upd_target = tgt; upd_mispredict = mp;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 4))
      0: r[31:26] = 6'($urandom_range(4, 7));
      1: begin
        r[31:26] = OP_REGIMM;
        if ($urandom_range(0, 1) == 1) r[20:16] = 5'($urandom_range(0, 1)) | 5'({$urandom_range(0, 1), 4'b0});
      end
      2: r[31:26] = 6'($urandom_range(2, 3));
      3: begin
        r[31:26] = OP_SPECIAL;
        if ($urandom_range(0, 2) != 0) r[5:0] = 6'($urandom_range(8, 9));
      end
      default: ;
    endcase
    return r;
  endfunction

  localparam logic [31:0] BEQ4 = 32'h1000_0004;
  localparam logic [31:0] JR   = 32'h03E0_0008;

  initial begin
    PC p;
    model_reset();
    rst_n = 1'b0;
    upd(1'b0, '0, BR_COND, 1'b0, '0, 1'b0);
    fetch(32'h0040_0000, BEQ4);
    #2;
    check_pred("reset");
    chk("reset.taken_c", 32'(inst_out.brunch_taken), 32'd0);
    tick(); tick();
    rst_n = 1'b1;

    #1;
    chk("beq.is_brunch", 32'(inst_out.is_brunch), 32'd1);
    chk("beq.nt_addr", brunch_address, 32'h0040_0004);
    check_pred("beq");

    upd(1'b1, 32'h0040_0000, BR_COND, 1'b1, '0, 1'b0);
    tick(); tick();
    upd(1'b0, '0, BR_COND, 1'b0, '0, 1'b0);
    #1;
    chk("beq.taken", 32'(inst_out.brunch_taken), 32'd1);
    chk("beq.t_addr", brunch_address, 32'h0040_0014);
    check_pred("beq_t");

    upd(1'b1, 32'h0040_0000, BR_COND, 1'b0, '0, 1'b0);
    repeat (4) tick();
    upd(1'b0, '0, BR_COND, 1'b0, '0, 1'b0);
    #1;
    chk("beq.sat0", 32'(inst_out.brunch_taken), 32'd0);
    check_pred("beq_sat");

    fetch(32'h1FFF_FFFC, {6'b000010, 26'h000_0010});
    #1;
    chk("j.addr", brunch_address, 32'h2000_0040);
    chk("j.taken", 32'(inst_out.brunch_taken), 32'd1);
    check_pred("j");

    fetch(32'h0040_0100, JR);
    #1;
    chk("jr.miss", 32'(inst_out.brunch_taken), 32'd0);
    check_pred("jr_miss");
    upd(1'b1, 32'h0040_0100, BR_INDIRECT, 1'b1, 32'h0040_1000, 1'b0);
    tick();
    upd(1'b0, '0, BR_COND, 1'b0, '0, 1'b0);
    #1;
    check_pred("jr_after");
`ifdef BRUNCH_BTB_EN
    chk("jr.hit", 32'(inst_out.brunch_taken), 32'd1);
    chk("jr.hit_addr", brunch_address, 32'h0040_1000);
`else
    chk("jr.nobtb", brunch_address, 32'h0040_0104);
`endif
    fetch(32'h0050_0100, JR);
    #1;
    chk("jr.alias", 32'(inst_out.brunch_taken), 32'd0);
    check_pred("jr_alias");

    fetch(32'h0040_0040, BEQ4);
    upd(1'b1, 32'h0040_0040, BR_COND, 1'b1, '0, 1'b0);
    #1;
    chk("same.old", 32'(inst_out.brunch_taken), 32'd0);
    check_pred("same_old");
    tick();
    upd(1'b0, '0, BR_COND, 1'b0, '0, 1'b0);
    #1;
    chk("same.new", 32'(inst_out.brunch_taken), 32'd1);
    check_pred("same_new");

    upd(1'b1, 32'h0040_0000, BR_DIRECT, 1'b1, '0, 1'b1);
    repeat (3) tick();
    upd(1'b0, 32'h0040_0000, BR_DIRECT, 1'b1, '0, 1'b1);
    tick();
    chk("miss.3", 32'(miss_count), 32'd3);
    upd(1'b1, 32'h0040_0000, BR_DIRECT, 1'b1, '0, 1'b1);
    repeat (10) tick();
    upd(1'b0, '0, BR_COND, 1'b0, '0, 1'b0);
    #1;
    chk("miss.sat", 32'(miss_count), 32'd7);

    for (int n = 0; n < 300; n++) begin
      p = 32'h0040_0000 + 32'(4 * $urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) p = p | 32'h0010_0000;
      fetch(p, rand_inst());
      p = 32'h0040_0000 + 32'(4 * $urandom_range(0, 15));
      upd(1'($urandom_range(0, 1)), p, BR_KIND'($urandom_range(1, 3)),
          1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC,
          1'($urandom_range(0, 1)));
      #1;
      check_pred("rand");
      tick();
    end

    upd(1'b1, 32'h0040_0040, BR_COND, 1'b1, '0, 1'b1);
    fetch(32'h0040_0040, BEQ4);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_pred("midrst");
    chk("midrst.miss", 32'(miss_count), 32'd0);
    tick();
    check_pred("midrst_edge");
    #2;
    rst_n = 1'b1;
    upd(1'b0, '0, BR_COND, 1'b0, '0, 1'b0);
    #1;
    chk("post.taken", 32'(inst_out.brunch_taken), 32'd0);
    check_pred("post_beq");
    fetch(32'h0040_0100, JR);
    #1;
    chk("post.jr", 32'(inst_out.brunch_taken), 32'd0);
    check_pred("post_jr");
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dynamic_brunch_predictor.md
# dynamic_brunch_predictor

Fetch-stage branch predictor with dynamic prediction. It decodes the fetched instruction, classifies it as conditional, direct, indirect or non-branch, and produces a same-cycle prediction plus a target. Per-PC 2-bit saturating counters (BHT) and an optional direct-mapped BTB are trained by a resolve/update port from the execute stage. It sits between the instruction memory output and the fetch PC mux, and drives `inst_out` and `brunch_address` in the same `INST`/`PC` types used elsewhere in fetch.

## Interface
- `BHT_ENTRIES`, 64: number of 2-bit counters; power of two, ≥2.
- `BTB_ENTRIES`, 16: number of BTB entries; power of two, ≥2. Used only with `BRUNCH_BTB_EN`.
- `CNT_WIDTH`, 2: counter width, ≥1; predicted taken when the counter MSB is 1.
- `MISS_CNT_WIDTH`, 32: width of the mispredict counter.
- `clk`  in  1  clock. One clock domain; all state updates on the rising edge.
- `rst_n`  in  1  reset. Asynchronous assert, active-low.
- `inst_in`  in  INST  fetched instruction; `.pc` and `.inst` are used.
- `inst_out`  out  INST  `.pc`/`.inst` passed through; `.is_brunch` and `.brunch_taken` are set by this block.
- `brunch_address`  out  PC  predicted next PC.
- `upd_valid`  in  1  resolved control-transfer instruction this cycle.
- `upd_pc`  in  PC  PC of the resolved instruction.
- `upd_kind`  in  BR_KIND  `BR_COND`, `BR_DIRECT` or `BR_INDIRECT`.
- `upd_taken`  in  1  actual outcome.
- `upd_target`  in  PC  actual target.
- `upd_mispredict`  in  1  execute stage flagged a misprediction.
- `miss_count`  out  MISS_CNT_WIDTH  saturating count of accepted `upd_mispredict` pulses.

## Operation
- Decode uses `op = inst[31:26]`:
  - conditional: BEQ/BNE/BLEZ/BGTZ (000100–000111); REGIMM (000001) with rt ∈ {00000, 00001, 10000, 10001}.
  - direct: J/JAL (000010/000011).
  - indirect: SPECIAL (000000) with funct JR (001000) or JALR (001001).
  - Anything else is a non-branch.
- `pc_4 = inst_in.pc + 4`, 32-bit with wrap.
- Direct: `is_brunch=1`, `taken=1`, `brunch_address = {pc_4[31:28], inst[25:0], 2'b00}`.
- Conditional:
  - `is_brunch=1`.
  - `taken = BHT[idx][CNT_WIDTH-1]`, where `idx = pc[log2(BHT_ENTRIES)+1:2]`.
  - Target = `pc_4 + sign_ext(inst[15:0]) << 2`.
- Indirect: `is_brunch=1`. Taken only on a BTB hit (valid && tag match), with the BTB target; otherwise `taken=0`.
- Non-branch, or not taken: `is_brunch` as classified, `taken=0`, `brunch_address = pc_4`.
- Every output is assigned on every path. No latches.
- Update, on a clock edge with `upd_valid=1`:
  - `BR_COND`: `BHT[upd_idx]` increments if taken, decrements otherwise, saturating at 0 and `2^CNT_WIDTH-1`.
  - `BR_INDIRECT` with `BRUNCH_BTB_EN`: write `{valid=1, tag=upd_pc[31:log2(BTB_ENTRIES)+2], target=upd_target}`.
  - `BR_DIRECT`: no table change.
- `miss_count` increments when `upd_valid && upd_mispredict`. It holds at all-ones.
- `upd_mispredict` is ignored when `upd_valid=0`.

## Timing
- Prediction is combinational from `inst_in` and the current table state: zero latency.
- Table writes take effect at the next rising edge. A lookup and update of the same index in the same cycle returns the old value. No bypass.
- Reset (`rst_n=0`), at any time including mid-update:
  - all counters go to weakly not-taken, `2^(CNT_WIDTH-1)-1` (01 for width 2);
  - all BTB valid bits clear;
  - `miss_count=0`.
  - An update presented during reset is dropped.
- Outputs during reset follow the combinational rules with the reset table state, so a conditional branch predicts not-taken.
- No handshake: the update port is fire-and-forget, one update per cycle, never stalled.

## Configuration
- `BRUNCH_BTB_EN` defined: BTB storage and update logic are compiled in, and indirect jumps can be predicted taken.
- Undefined: no BTB storage. Indirect jumps report `is_brunch=1`, `taken=0`, `brunch_address=pc_4`, and `BR_INDIRECT` updates are ignored.

## Structure
- Shared defines package (alongside `INST`, `PC`):
  - `BR_KIND` enum;
  - opcode/funct/rt constants for the branch encodings;
  - `BHT_WEAK_NT` reset constant helper.
- Natural sub-module: `brunch_btb` (direct-mapped tag/target/valid array with asynchronous-reset valid bits, combinational read, synchronous write), instantiated only under `BRUNCH_BTB_EN`.

## Test plan
- Reset, then BEQ at PC 0x00400000 with imm 0x0004 -> `is_brunch=1`, `taken=0`, `brunch_address=0x00400004`.
- Two `BR_COND` taken updates for PC 0x00400000, then same fetch -> `taken=1`, `brunch_address=0x00400014`. Four not-taken updates -> counter saturates at 0, predicts not-taken.
- J at PC 0x1FFFFFFC with target field 0x0000010 -> `brunch_address=0x20000040`, `taken=1`, independent of tables.
- With `BRUNCH_BTB_EN`: JR at 0x00400100 misses (`taken=0`). After a `BR_INDIRECT` update with target 0x00401000 it hits (`taken=1`, `brunch_address=0x00401000`). An aliasing PC with a different tag misses.
- Same-cycle update and lookup of one index -> old prediction this cycle, new one next cycle. Assert `rst_n` mid-stream -> counters back to 01, BTB invalid, `miss_count=0`.
- Drive 3 `upd_mispredict` pulses with `upd_valid=1` and 1 with `upd_valid=0` -> `miss_count=3`. Preload near all-ones -> holds at all-ones.
